// File: rtl/wb_master_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// wb_master_arbiter_pkg
//   Shared definitions for the two-master Wishbone arbiter:
//   - FSM state codes (kept as fixed 2-bit encodings so existing debug
//     tooling that decodes the state register keeps working)
//   - one-hot grant encodings as presented on o_grant
//   - default abort data word
//   - helper to size the watchdog counter
// ----------------------------------------------------------------------------
package wb_master_arbiter_pkg;

  // Arbiter FSM state encodings
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_OWN0 = 2'd1;
  localparam logic [1:0] ST_OWN1 = 2'd2;

  // Grant encodings, {m1, m0}
  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_M0   = 2'b01;
  localparam logic [1:0] GNT_M1   = 2'b10;

  // Read data returned to a master whose access was aborted by the watchdog
  localparam logic [31:0] DEFAULT_TIMEOUT_DATA = 32'hDEADBEEF;

  // Counter width able to hold 0..cycles; never narrower than one bit so a
  // disabled watchdog (cycles == 0) still elaborates cleanly.
  function automatic int unsigned wdog_width(input int unsigned cycles);
    int unsigned w;
    w = $clog2(cycles + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/wb_watchdog.sv
// ----------------------------------------------------------------------------
// wb_watchdog
//   Bus watchdog counter. Counts cycles while en is high; expire pulses
//   combinationally in the cycle the count reaches LIMIT-1 with en still
//   high, i.e. on the LIMIT-th consecutive enabled cycle. The counter
//   restarts on clr or on expiry. LIMIT == 0 disables expiry entirely.
//
// Ports
//   clk     in  clock
//   rst     in  asynchronous active-high reset
//   clr     in  synchronous clear of the count
//   en      in  count enable (stalled strobe)
//   expire  out one-cycle abort pulse
// ----------------------------------------------------------------------------
module wb_watchdog
  import wb_master_arbiter_pkg::*;
#(
  parameter int unsigned LIMIT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int unsigned W = wdog_width(LIMIT);
  localparam logic [W-1:0] LAST = (LIMIT == 0) ? '0 : W'(LIMIT - 1);

  logic [W-1:0] count;

  always_comb begin
    expire = 1'b0;
    if (LIMIT != 0) begin
      expire = en && (count == LAST);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr || expire) begin
      count <= '0;
    end else if (en) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/wb_master_arbiter.sv
// ----------------------------------------------------------------------------
// wb_master_arbiter
//   Two-master, one-slave Wishbone classic arbiter sharing the on-chip
//   memory between the core/debug master (m0) and the UART bridge (m1).
//   Ownership is granted (registered) from IDLE and held for the whole cyc
//   burst of the owner. The owner's strobe is re-gated after each ack so a
//   master that keeps stb high cannot re-trigger the slave; dropping stb for
//   a cycle re-arms it for another access inside the same cyc. A watchdog
//   completes a hung access with ack+err and TIMEOUT_DATA.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   mN_cyc_i/stb_i/we_i      master N cycle, strobe, write enable
//   mN_adr_i/dat_i           master N address, write data
//   mN_dat_o                 master N read data (held between acks)
//   mN_ack_o/err_o           master N acknowledge / watchdog error
//   s_cyc_o/stb_o/we_o       slave cycle, strobe, write enable
//   s_adr_o/dat_o            slave address, write data
//   s_dat_i/ack_i            slave read data, acknowledge
//   o_grant                  one-hot owner {m1,m0}, 00 when idle
//   o_timeout                one-cycle pulse on watchdog abort
// ----------------------------------------------------------------------------
module wb_master_arbiter
  import wb_master_arbiter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 16,
  parameter int unsigned ROUND_ROBIN    = 1,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [DATA_WIDTH-1:0] TIMEOUT_DATA = DATA_WIDTH'(DEFAULT_TIMEOUT_DATA)
) (
  input  logic                  clk,
  input  logic                  rst,
  // master 0 (core/debug)
  input  logic                  m0_cyc_i,
  input  logic                  m0_stb_i,
  input  logic                  m0_we_i,
  input  logic [ADDR_WIDTH-1:0] m0_adr_i,
  input  logic [DATA_WIDTH-1:0] m0_dat_i,
  output logic [DATA_WIDTH-1:0] m0_dat_o,
  output logic                  m0_ack_o,
  output logic                  m0_err_o,
  // master 1 (UART bridge)
  input  logic                  m1_cyc_i,
  input  logic                  m1_stb_i,
  input  logic                  m1_we_i,
  input  logic [ADDR_WIDTH-1:0] m1_adr_i,
  input  logic [DATA_WIDTH-1:0] m1_dat_i,
  output logic [DATA_WIDTH-1:0] m1_dat_o,
  output logic                  m1_ack_o,
  output logic                  m1_err_o,
  // slave
  output logic                  s_cyc_o,
  output logic                  s_stb_o,
  output logic                  s_we_o,
  output logic [ADDR_WIDTH-1:0] s_adr_o,
  output logic [DATA_WIDTH-1:0] s_dat_o,
  input  logic [DATA_WIDTH-1:0] s_dat_i,
  input  logic                  s_ack_i,
  // status
  output logic [1:0]            o_grant,
  output logic                  o_timeout
);

  logic [1:0]            state;
  logic                  last;   // index of the most recently granted master
  logic                  done;   // owner's current access already completed
  logic [DATA_WIDTH-1:0] hold0;
  logic [DATA_WIDTH-1:0] hold1;

  logic own0, own1, owned;
  logic own_cyc, own_stb;
  logic acked;
  logic wd_en, wd_clr, expire;

  assign own0  = (state == ST_OWN0);
  assign own1  = (state == ST_OWN1);
  assign owned = own0 | own1;

  // --------------------------------------------------------------------------
  // Slave-side multiplexer from the current owner; all zero while idle so
  // an asynchronous reset drops every slave output immediately.
  // --------------------------------------------------------------------------
  always_comb begin
    own_cyc = 1'b0;
    own_stb = 1'b0;
    s_we_o  = 1'b0;
    s_adr_o = '0;
    s_dat_o = '0;
    if (own0) begin
      own_cyc = m0_cyc_i;
      own_stb = m0_stb_i;
      s_we_o  = m0_we_i;
      s_adr_o = m0_adr_i;
      s_dat_o = m0_dat_i;
    end else if (own1) begin
      own_cyc = m1_cyc_i;
      own_stb = m1_stb_i;
      s_we_o  = m1_we_i;
      s_adr_o = m1_adr_i;
      s_dat_o = m1_dat_i;
    end
  end

  assign s_cyc_o = owned;
  // Gating with own_cyc makes an abandoned access drop stb in the same cycle
  // the owner releases cyc, even if the master leaves stb asserted.
  assign s_stb_o = own_cyc & own_stb & ~done;
  // A slave ack only counts while a strobe is presented; stray acks vanish.
  assign acked   = s_stb_o & s_ack_i;

  // --------------------------------------------------------------------------
  // Watchdog: counts consecutive stalled strobe cycles. Any cycle without a
  // stalled strobe (ack, strobe gone, state exit) restarts it.
  // --------------------------------------------------------------------------
  assign wd_en  = s_stb_o & ~s_ack_i;
  assign wd_clr = ~wd_en;

  wb_watchdog #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clr    (wd_clr),
    .en     (wd_en),
    .expire (expire)
  );

  // --------------------------------------------------------------------------
  // Master-side responses
  // --------------------------------------------------------------------------
  always_comb begin
    m0_ack_o = own0 & (acked | expire);
    m0_err_o = own0 & expire;
    m1_ack_o = own1 & (acked | expire);
    m1_err_o = own1 & expire;

    m0_dat_o = hold0;
    if (own0 && acked) begin
      m0_dat_o = s_dat_i;
    end else if (own0 && expire) begin
      m0_dat_o = TIMEOUT_DATA;
    end

    m1_dat_o = hold1;
    if (own1 && acked) begin
      m1_dat_o = s_dat_i;
    end else if (own1 && expire) begin
      m1_dat_o = TIMEOUT_DATA;
    end
  end

  assign o_grant   = {own1, own0};
  assign o_timeout = expire;

  // --------------------------------------------------------------------------
  // Arbitration FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      last  <= 1'b1;
      done  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (m0_cyc_i && m1_cyc_i) begin
            // Round robin hands the bus to the master not served last;
            // fixed priority always favours m0.
            if ((ROUND_ROBIN != 0) && !last) begin
              state <= ST_OWN1;
              last  <= 1'b1;
            end else begin
              state <= ST_OWN0;
              last  <= 1'b0;
            end
          end else if (m0_cyc_i) begin
            state <= ST_OWN0;
            last  <= 1'b0;
          end else if (m1_cyc_i) begin
            state <= ST_OWN1;
            last  <= 1'b1;
          end
        end

        ST_OWN0, ST_OWN1: begin
          if (!own_cyc) begin
            // Burst ends; IDLE is a mandatory dead cycle before regrant.
            state <= ST_IDLE;
            done  <= 1'b0;
          end else if (acked || expire) begin
            done <= 1'b1;
          end else if (!own_stb) begin
            done <= 1'b0;
          end
        end

        default: begin
          state <= ST_IDLE;
          done  <= 1'b0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Read data holding registers; survive cyc release until the next ack.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold0 <= '0;
      hold1 <= '0;
    end else begin
      if (own0 && acked) begin
        hold0 <= s_dat_i;
      end else if (own0 && expire) begin
        hold0 <= TIMEOUT_DATA;
      end
      if (own1 && acked) begin
        hold1 <= s_dat_i;
      end else if (own1 && expire) begin
        hold1 <= TIMEOUT_DATA;
      end
    end
  end

endmodule

// File: tb/tb_wb_master_arbiter.sv
// ----------------------------------------------------------------------------
// tb_wb_master_arbiter
//   Directed bench for wb_master_arbiter. Instance a: round robin, 8-cycle
//   watchdog. Instance b: fixed priority, shares every input with a.
//   Expected master responses are queued when an access is issued; a monitor
//   pops and compares them whenever instance a acknowledges a master.
// ----------------------------------------------------------------------------
module tb_wb_master_arbiter;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          m0_cyc = 1'b0, m0_stb = 1'b0, m0_we = 1'b0;
  logic [AW-1:0] m0_adr = '0;
  logic [DW-1:0] m0_dat = '0;
  logic          m1_cyc = 1'b0, m1_stb = 1'b0, m1_we = 1'b0;
  logic [AW-1:0] m1_adr = '0;
  logic [DW-1:0] m1_dat = '0;
  logic [DW-1:0] s_dat_i = '0;
  logic          s_ack_i = 1'b0;

  logic [DW-1:0] a_m0_dat_o, a_m1_dat_o, a_s_dat_o;
  logic          a_m0_ack_o, a_m0_err_o, a_m1_ack_o, a_m1_err_o;
  logic          a_s_cyc_o, a_s_stb_o, a_s_we_o, a_o_timeout;
  logic [AW-1:0] a_s_adr_o;
  logic [1:0]    a_o_grant;

  logic [DW-1:0] b_m0_dat_o, b_m1_dat_o, b_s_dat_o;
  logic          b_m0_ack_o, b_m0_err_o, b_m1_ack_o, b_m1_err_o;
  logic          b_s_cyc_o, b_s_stb_o, b_s_we_o, b_o_timeout;
  logic [AW-1:0] b_s_adr_o;
  logic [1:0]    b_o_grant;

  wb_master_arbiter #(
    .DATA_WIDTH     (DW),
    .ADDR_WIDTH     (AW),
    .ROUND_ROBIN    (1),
    .TIMEOUT_CYCLES (8),
    .TIMEOUT_DATA   (32'hDEADBEEF)
  ) dut_a (
    .clk(clk), .rst(rst),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_adr_i(m0_adr), .m0_dat_i(m0_dat),
    .m0_dat_o(a_m0_dat_o), .m0_ack_o(a_m0_ack_o), .m0_err_o(a_m0_err_o),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_adr_i(m1_adr), .m1_dat_i(m1_dat),
    .m1_dat_o(a_m1_dat_o), .m1_ack_o(a_m1_ack_o), .m1_err_o(a_m1_err_o),
    .s_cyc_o(a_s_cyc_o), .s_stb_o(a_s_stb_o), .s_we_o(a_s_we_o), .s_adr_o(a_s_adr_o),
    .s_dat_o(a_s_dat_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
    .o_grant(a_o_grant), .o_timeout(a_o_timeout)
  );

  wb_master_arbiter #(
    .DATA_WIDTH     (DW),
    .ADDR_WIDTH     (AW),
    .ROUND_ROBIN    (0),
    .TIMEOUT_CYCLES (8),
    .TIMEOUT_DATA   (32'hDEADBEEF)
  ) dut_b (
    .clk(clk), .rst(rst),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_adr_i(m0_adr), .m0_dat_i(m0_dat),
    .m0_dat_o(b_m0_dat_o), .m0_ack_o(b_m0_ack_o), .m0_err_o(b_m0_err_o),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_adr_i(m1_adr), .m1_dat_i(m1_dat),
    .m1_dat_o(b_m1_dat_o), .m1_ack_o(b_m1_ack_o), .m1_err_o(b_m1_err_o),
    .s_cyc_o(b_s_cyc_o), .s_stb_o(b_s_stb_o), .s_we_o(b_s_we_o), .s_adr_o(b_s_adr_o),
    .s_dat_o(b_s_dat_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
    .o_grant(b_o_grant), .o_timeout(b_o_timeout)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  function automatic logic [127:0] a_outs();
    return 128'({a_s_cyc_o, a_s_stb_o, a_s_we_o, a_s_adr_o, a_s_dat_o,
                 a_m0_ack_o, a_m0_err_o, a_m1_ack_o, a_m1_err_o,
                 a_m0_dat_o, a_m1_dat_o, a_o_grant, a_o_timeout});
  endfunction

  // ------------------------------------------------------------------ slave
  // Acks the a-side strobe in its slv_delay-th cycle with slv_data; acks are
  // one cycle long. stray forces an ack regardless of strobe.
  int unsigned   slv_delay = 3;
  logic [DW-1:0] slv_data  = '0;
  bit            slv_en    = 1'b1;
  bit            stray     = 1'b0;
  int unsigned   wcnt      = 0;

  always @(posedge clk) begin
    #2;
    if (stray) begin
      s_ack_i = 1'b1;
    end else if (s_ack_i) begin
      s_ack_i = 1'b0;
      wcnt    = 0;
    end else if (a_s_stb_o && slv_en) begin
      if (wcnt + 1 >= slv_delay) begin
        s_ack_i = 1'b1;
        s_dat_i = slv_data;
        wcnt    = 0;
      end else begin
        wcnt++;
      end
    end else begin
      wcnt = 0;
    end
  end

  // ------------------------------------------------------------- scoreboard
  typedef struct packed {
    logic          who;
    logic          err;
    logic [DW-1:0] data;
  } exp_t;

  exp_t sb[$];

  always @(negedge clk) begin
    if (!rst && (a_m0_ack_o || a_m1_ack_o)) begin
      check("ack_expected", 128'(sb.size() != 0), 128'(1'b1));
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        check("master_response",
              128'({a_m1_ack_o, a_m0_ack_o,
                    (a_m1_ack_o ? a_m1_err_o : a_m0_err_o), a_o_timeout,
                    (a_m1_ack_o ? a_m1_dat_o : a_m0_dat_o)}),
              128'({e.who, ~e.who, e.err, e.err, e.data}));
      end
    end
  end

  int unsigned rises = 0;
  logic        stb_q = 1'b0;
  always @(negedge clk) begin
    if (a_s_stb_o && !stb_q) rises++;
    stb_q = a_s_stb_o;
  end

  // ------------------------------------------------------------- helpers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input logic who, input int unsigned limit);
    bit seen;
    seen = 1'b0;
    for (int unsigned i = 0; i < limit && !seen; i++) begin
      @(negedge clk);
      if (who ? a_m1_ack_o : a_m0_ack_o) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL ack_wait: m%0d saw no ack within %0d cycles, required one", who, limit);
    end
  endtask

  // ------------------------------------------------------------- stimulus
  initial begin
    int unsigned n;
    int unsigned r0;
    bit          got_ack;

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", a_outs(), '0);
    tick();
    rst = 1'b0;
    tick();

    // m1 read, 3-cycle slave, then m1 keeps stb after ack
    slv_delay = 3;
    slv_data  = 32'h12345678;
    sb.push_back('{who: 1'b1, err: 1'b0, data: 32'h12345678});
    m1_cyc = 1'b1; m1_stb = 1'b1; m1_we = 1'b0; m1_adr = 16'h0010;
    tick();
    @(negedge clk);
    check("m1_grant", 128'({a_o_grant, a_s_cyc_o, a_s_adr_o}), 128'({2'b10, 1'b1, 16'h0010}));
    wait_ack(1'b1, 20);
    tick();
    @(negedge clk);
    check("stb_regated", 128'({a_s_stb_o, a_m1_ack_o, a_m1_dat_o}), 128'({1'b0, 1'b0, 32'h12345678}));
    tick();
    m1_cyc = 1'b0; m1_stb = 1'b0;
    tick();
    tick();
    @(negedge clk);
    check("m1_dat_held", 128'({a_o_grant, a_m1_dat_o}), 128'({2'b00, 32'h12345678}));

    // simultaneous requests: round robin alternates, fixed priority keeps m0
    tick();
    m0_cyc = 1'b1; m1_cyc = 1'b1;
    tick();
    @(negedge clk);
    check("arb_first", 128'({a_o_grant, b_o_grant}), 128'({2'b01, 2'b01}));
    tick();
    m0_cyc = 1'b0; m1_cyc = 1'b0;
    tick();
    tick();
    m0_cyc = 1'b1; m1_cyc = 1'b1;
    tick();
    @(negedge clk);
    check("arb_second", 128'({a_o_grant, b_o_grant}), 128'({2'b10, 2'b01}));
    tick();
    m0_cyc = 1'b0; m1_cyc = 1'b0;
    tick();
    tick();

    // m0 write while m1 waits, then handover with one dead cycle
    slv_delay = 2;
    slv_data  = 32'h0BADF00D;
    sb.push_back('{who: 1'b0, err: 1'b0, data: 32'h0BADF00D});
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = 1'b1; m0_adr = 16'h0004; m0_dat = 32'hA5A5A5A5;
    tick();
    m1_cyc = 1'b1; m1_stb = 1'b1; m1_we = 1'b0; m1_adr = 16'h0020;
    @(negedge clk);
    check("m0_write_bus",
          128'({a_o_grant, a_s_cyc_o, a_s_stb_o, a_s_we_o, a_s_adr_o, a_s_dat_o}),
          128'({2'b01, 1'b1, 1'b1, 1'b1, 16'h0004, 32'hA5A5A5A5}));
    wait_ack(1'b0, 20);
    slv_data = 32'h00C0FFEE;
    sb.push_back('{who: 1'b1, err: 1'b0, data: 32'h00C0FFEE});
    tick();
    m0_stb = 1'b0;
    @(negedge clk);
    check("m1_waits", 128'({a_o_grant, a_m1_ack_o}), 128'({2'b01, 1'b0}));
    tick();
    m0_cyc = 1'b0;
    @(negedge clk);
    check("release_cycle", 128'({a_o_grant, a_s_stb_o}), 128'({2'b01, 1'b0}));
    tick();
    @(negedge clk);
    check("dead_cycle", 128'({a_o_grant, a_s_cyc_o}), 128'({2'b00, 1'b0}));
    tick();
    @(negedge clk);
    check("m1_regrant", 128'({a_o_grant, a_s_adr_o, a_s_we_o}), 128'({2'b10, 16'h0020, 1'b0}));
    wait_ack(1'b1, 20);
    tick();
    m1_cyc = 1'b0; m1_stb = 1'b0;
    tick();
    tick();

    // watchdog abort on the 8th stalled strobe cycle
    slv_en = 1'b0;
    sb.push_back('{who: 1'b0, err: 1'b1, data: 32'hDEADBEEF});
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = 1'b0; m0_adr = 16'h0040;
    n = 0;
    got_ack = 1'b0;
    for (int i = 0; i < 30 && !got_ack; i++) begin
      @(negedge clk);
      if (a_s_stb_o) n++;
      if (a_m0_ack_o) got_ack = 1'b1;
    end
    if (!got_ack) begin
      checks++;
      errors++;
      $display("FAIL timeout_wait: no watchdog ack within 30 cycles, required one");
    end
    check("timeout_cycle", 128'(n), 128'(8));
    tick();
    @(negedge clk);
    check("timeout_after",
          128'({a_o_grant, a_s_stb_o, a_m0_ack_o, a_o_timeout, a_m0_dat_o}),
          128'({2'b01, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF}));
    tick();
    m0_cyc = 1'b0; m0_stb = 1'b0;
    slv_en = 1'b1;
    tick();
    tick();

    // two accesses inside one cyc, stb low for one cycle between them
    slv_delay = 1;
    slv_data  = 32'h11111111;
    sb.push_back('{who: 1'b0, err: 1'b0, data: 32'h11111111});
    r0 = rises;
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 16'h0080;
    wait_ack(1'b0, 20);
    tick();
    m0_stb = 1'b0;
    tick();
    slv_data = 32'h22222222;
    sb.push_back('{who: 1'b0, err: 1'b0, data: 32'h22222222});
    m0_stb = 1'b1;
    wait_ack(1'b0, 20);
    tick();
    m0_cyc = 1'b0; m0_stb = 1'b0;
    tick();
    check("two_strobes", 128'(rises - r0), 128'(2));
    tick();

    // stray slave ack while idle
    stray = 1'b1;
    @(negedge clk);
    check("stray_ignored", 128'({a_o_grant, a_m0_ack_o, a_m1_ack_o, a_s_cyc_o}), '0);
    tick();
    stray = 1'b0;
    tick();
    tick();

    // reset while m1 owns the bus with an access pending
    slv_en = 1'b0;
    m1_cyc = 1'b1; m1_stb = 1'b1; m1_adr = 16'h0030;
    tick();
    tick();
    @(negedge clk);
    check("own1_pending", 128'({a_o_grant, a_s_stb_o}), 128'({2'b10, 1'b1}));
    #2;
    rst = 1'b1;
    #1;
    check("async_reset", a_outs(), '0);
    m1_cyc = 1'b0; m1_stb = 1'b0;
    tick();
    rst = 1'b0;
    slv_en = 1'b1;
    tick();
    @(negedge clk);
    check("idle_after_reset", 128'({a_o_grant, a_s_cyc_o, a_m1_dat_o}), '0);

    check("sb_drained", 128'(sb.size()), '0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
